// File: rtl/cache_data_block.sv
// Single-port data array for one cache way.
// Synchronous write, combinational read, async clear on reset.
module cache_data_block #(
  parameter int NUM_OF_ENTRY = 1024,
  parameter int ENTRY_WIDTH  = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ENTRY_WIDTH-1:0] index,
  input  logic                   we,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  dout
);

  localparam logic [ENTRY_WIDTH:0] N_ENT =
    NUM_OF_ENTRY[ENTRY_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [NUM_OF_ENTRY];
  logic                  in_range;

  // Indices past the last entry neither alias nor wrap.
  assign in_range = {1'b0, index} < N_ENT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OF_ENTRY; i++) begin
        mem[i] <= '0;
      end
    end else if (we && in_range) begin
      mem[index] <= din;
    end
  end

  always_comb begin
    dout = '0;
    if (in_range) begin
      dout = mem[index];
    end
  end

endmodule

// File: tb/tb_cache_data_block.sv
// Self-checking bench for cache_data_block.
// Expected read values are queued at stimulus and popped on sampling.
module tb_cache_data_block;

  localparam int N  = 1024;
  localparam int EW = 10;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [EW-1:0] index;
  logic          we;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;

  typedef struct {
    string         tag;
    logic [DW-1:0] val;
  } exp_t;

  exp_t          exp_q [$];
  logic [DW-1:0] model [N];
  int            n_tests;
  int            n_fail;

  cache_data_block #(
    .NUM_OF_ENTRY(N),
    .ENTRY_WIDTH (EW),
    .DATA_WIDTH  (DW),
    .OFFSET_WIDTH(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .index(index),
    .we   (we),
    .din  (din),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [DW-1:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'h1, 32'h0);
    end else begin
      e = exp_q.pop_front();
      chk(e.tag, dout, e.val);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) model[i] = '0;
  endtask

  task automatic wr(input logic [EW-1:0] idx,
                    input logic [DW-1:0] d);
    @(negedge clk);
    index = idx;
    din   = d;
    we    = 1'b1;
    @(posedge clk);
    if (!rst) model[idx] = d;
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [EW-1:0] idx,
                    input logic [DW-1:0] exp);
    @(negedge clk);
    index = idx;
    push(tag, exp);
    sample();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear_model();
    rst   = 1'b1;
    we    = 1'b0;
    index = '0;
    din   = '0;
    repeat (2) @(posedge clk);
    rd("reset_idx0", 10'd0, 32'h0);
    rd("reset_idx2", 10'd2, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    wr(10'd2, 32'hDEADBEEF);
    rd("pre_clear", 10'd2, 32'hDEADBEEF);
    @(negedge clk);
    #2;
    rst = 1'b1;
    clear_model();
    push("clear_in_rst", 32'h0);
    sample();
    @(negedge clk);
    rst = 1'b0;
    rd("clear_after_rst", 10'd2, 32'h0);

    @(negedge clk);
    index = 10'd2;
    din   = 32'h00000FF0;
    we    = 1'b1;
    push("before_edge", 32'h0);
    sample();
    @(posedge clk);
    #1;
    we = 1'b0;
    push("after_edge", 32'h00000FF0);
    sample();
    din = 32'h12345678;
    repeat (3) @(posedge clk);
    rd("hold_we0", 10'd2, 32'h00000FF0);

    rd("iso_idx3", 10'd3, 32'h0);
    rd("iso_idx2", 10'd2, 32'h00000FF0);

    wr(10'd0, 32'hA5A5A5A5);
    wr(10'd1023, 32'h5A5A5A5A);
    rd("bound_idx0", 10'd0, 32'hA5A5A5A5);
    rd("bound_idx1023", 10'd1023, 32'h5A5A5A5A);
    rd("bound_idx512", 10'd512, 32'h0);

    @(negedge clk);
    index = 10'd7;
    din   = 32'h1;
    we    = 1'b1;
    @(negedge clk);
    din = 32'h2;
    @(negedge clk);
    we = 1'b0;
    rd("consec_idx7", 10'd7, 32'h2);

    @(negedge clk);
    rst   = 1'b1;
    index = 10'd4;
    din   = 32'hFFFFFFFF;
    we    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    we  = 1'b0;
    rst = 1'b0;
    clear_model();
    rd("wr_in_rst_idx4", 10'd4, 32'h0);
    rd("rst_cleared_idx0", 10'd0, 32'h0);

    for (int k = 0; k < 40; k++) begin
      logic [EW-1:0] ri;
      logic [DW-1:0] rdat;
      logic          rwe;
      ri   = EW'($urandom_range(100, 115));
      rdat = $urandom;
      rwe  = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      index = ri;
      din   = rdat;
      we    = rwe;
      push("rand_old", model[ri]);
      sample();
      @(posedge clk);
      if (rwe) model[ri] = rdat;
      #1;
      we = 1'b0;
      push("rand_new", model[ri]);
      sample();
    end

    if (exp_q.size() != 0) chk("scoreboard_left", 32'h1, 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_data_block.md
# cache_data_block

Single-port data storage array for one cache way: `NUM_OF_ENTRY` words of `DATA_WIDTH` bits, addressed by a set index. It sits under the cache controller, which supplies the index and write enable and consumes the read data. Writes are synchronous. Reads are combinational from the addressed entry.

## Interface
Parameters:
- `NUM_OF_ENTRY`, default 1024 (`_1K): number of entries.
- `ENTRY_WIDTH`, default 10: index width; must satisfy 2^ENTRY_WIDTH >= NUM_OF_ENTRY.
- `DATA_WIDTH`, default 32 (`_4B): bits per entry.
- `OFFSET_WIDTH`, default 2: byte-offset width of the enclosing cache. Informational only; the block does no byte selection.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous active-high reset.
- `index`  in  ENTRY_WIDTH  entry selected for both read and write.
- `we`  in  1  write enable, sampled at rising `clk`.
- `din`  in  DATA_WIDTH  write data.
- `dout`  out  DATA_WIDTH  current contents of entry `index`.

## Operation
- Storage is an array `mem[0..NUM_OF_ENTRY-1]` of DATA_WIDTH-bit words.
- Reset:
  - While `rst`=1, every entry is cleared to 0, independent of `clk`.
  - `dout` therefore reads 0 for any index during reset and after reset until a write occurs.
  - A write is never performed while `rst`=1, even if `we`=1 at a clock edge.
- Write: at a rising `clk` with `rst`=0 and `we`=1, `mem[index]` <= `din`. Only that entry changes.
- Read: `dout` = `mem[index]` combinationally. There is no enable and no register.
- No write-through bypass:
  - Within the cycle a write is set up, `dout` shows the old contents.
  - The new value appears right after the capturing edge.
- Out-of-range index (index >= NUM_OF_ENTRY, possible only when NUM_OF_ENTRY < 2^ENTRY_WIDTH):
  - a write is ignored, with no aliasing or wrap;
  - `dout` = 0.
- `we`=0 retains all contents indefinitely; changes on `din` have no effect.
- There is no state machine, no handshake and no busy state. A write is accepted every cycle.

## Timing
- Write latency: 1 edge. Data is visible on `dout` after the rising edge that sampled `we`=1.
- Read latency: 0 cycles, combinational from `index` and array contents. A change of `index` is reflected in the same cycle.
- Back-to-back writes to the same index on consecutive edges: the last write wins.
- Write to index A while reading a different index B is impossible. The block is single-port and `index` selects both.
- Reset:
  - Assertion clears the array immediately, asynchronously, including mid-operation; a write in flight at that edge is lost.
  - After deassertion, the first write takes effect at the first rising edge with `rst`=0 and `we`=1.
- All outputs at reset: `dout` = 0.

## Test plan
- Reset clear:
  - write 0xDEADBEEF to index 2, then assert `rst`;
  - `dout` at index 2 must read 0x00000000 while `rst` is high and after release.
- Basic write/read:
  - after reset, index=2, din=0x00000FF0, pulse `we` for one cycle;
  - `dout`=0 before the edge and 0x00000FF0 after it;
  - with `we` low and din changed to 0x12345678, `dout` stays 0x00000FF0.
- Isolation: after the write above, index=3 gives `dout`=0; index=2 again gives 0x00000FF0.
- Boundaries: write 0xA5A5A5A5 to index 0 and 0x5A5A5A5A to index 1023; read both back exactly, and index 512 reads 0.
- Consecutive writes: index=7, write 0x1 then 0x2 on successive edges -> `dout`=0x2.
- Write during reset: hold `rst`=1 with we=1, index=4, din=0xFFFFFFFF across several edges -> after release, index 4 reads 0.
